// File: rtl/aoc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aoc_pkg : shared types and constants for max_subseq_picker            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif

package aoc_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        POP  = 2'd1,
        CONV = 2'd2,
        EMIT = 2'd3
    } state_t;

    typedef logic [`DATA_WIDTH-1:0] digit_t;

    localparam int unsigned TEN = 10;

endpackage

`default_nettype wire

// File: rtl/digit_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | digit_stack : LIFO of decimal digits with peek-top and indexed read   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module digit_stack
    import aoc_pkg::*;
#(
    parameter int DIGITS = 12,
    parameter int DW     = $clog2(DIGITS + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  digit_t        push_data,
    output digit_t        top,
    output logic [DW-1:0] depth,
    input  logic [DW-1:0] rd_idx,
    output digit_t        rd_data
);

    // Storage rounded up to a power of two so every index value is in range
    localparam int SLOTS = 1 << DW;

    digit_t        r_mem [SLOTS];
    logic [DW-1:0] r_depth;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_depth <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_depth <= '0;
        end else if (pop) begin
            r_depth <= r_depth - DW'(1);
        end else if (push) begin
            r_mem[r_depth] <= push_data;
            r_depth        <= r_depth + DW'(1);
        end
    end

    assign top     = (r_depth == '0) ? '0 : r_mem[r_depth - DW'(1)];
    assign depth   = r_depth;
    assign rd_data = r_mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/max_subseq_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | max_subseq_picker : keeps the largest DIGITS-long subsequence of each |
// | line and emits it as binary. Macro MAX_SUBSEQ_PICKER_ACC_EN adds the  |
// | running total and its clear input.                                   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module max_subseq_picker
    import aoc_pkg::*;
#(
    parameter int DIGITS      = 12,
    parameter int LINE_LEN    = 100,
    parameter int VALUE_WIDTH = 40,
    parameter int SUM_WIDTH   = 64
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`DATA_WIDTH-1:0] in_digit,
    input  logic                   in_last,
    input  logic                   clear,
    output logic                   out_valid,
    output logic [VALUE_WIDTH-1:0] out_value,
    output logic                   out_err,
    output logic [SUM_WIDTH-1:0]   total,
    output logic                   busy
);

    localparam int DW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(LINE_LEN + 1);

    state_t                 r_state, w_state_nxt;
    logic [IW-1:0]          r_idx;
    digit_t                 r_pend_digit;
    logic                   r_pend_last;
    logic                   r_err;
    logic [DW-1:0]          r_conv_idx;
    logic [VALUE_WIDTH-1:0] r_acc;

    digit_t        w_top, w_rd_data, w_cur_digit;
    logic [DW-1:0] w_depth;
    logic          w_take, w_act, w_pop, w_push, w_place_done;
    logic          w_at_end, w_in_last, w_in_err, w_cur_last;
    logic [31:0]   w_rem, w_avail;

    digit_stack #(.DIGITS(DIGITS)) u_stack (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (w_push),
        .pop       (w_pop),
        .flush     (r_state == EMIT),
        .push_data (w_cur_digit),
        .top       (w_top),
        .depth     (w_depth),
        .rd_idx    (r_conv_idx),
        .rd_data   (w_rd_data)
    );

    assign w_take    = (r_state == FILL) && in_valid;
    assign w_at_end  = (r_idx == IW'(LINE_LEN - 1));
    assign w_in_last = in_last || w_at_end;
    assign w_in_err  = in_last ^ w_at_end;

    assign w_act       = w_take || (r_state == POP);
    assign w_cur_digit = (r_state == POP) ? r_pend_digit : in_digit;
    assign w_cur_last  = (r_state == POP) ? r_pend_last  : w_in_last;

    // A terminating digit has nothing after it, whatever its index
    assign w_rem = w_cur_last                        ? 32'd1 :
                   (32'(r_idx) >= 32'(LINE_LEN - 1)) ? 32'd1 :
                   32'(LINE_LEN) - 32'(r_idx);
    // depth-1+r >= DIGITS rewritten as depth+r > DIGITS to stay unsigned
    assign w_avail = 32'(w_depth) + w_rem;

    assign w_pop        = w_act && (w_depth != '0) && (w_top < w_cur_digit)
                          && (w_avail > 32'(DIGITS));
    assign w_push       = w_act && !w_pop && (32'(w_depth) < 32'(DIGITS));
    assign w_place_done = w_act && !w_pop;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FILL: begin
                if (w_take) begin
                    if (w_pop)          w_state_nxt = POP;
                    else if (w_in_last) w_state_nxt = CONV;
                end
            end
            POP: begin
                if (!w_pop) w_state_nxt = r_pend_last ? CONV : FILL;
            end
            CONV: begin
                if (32'(r_conv_idx) + 32'd1 >= 32'(w_depth)) w_state_nxt = EMIT;
            end
            EMIT:    w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_pend_digit <= '0;
            r_pend_last  <= 1'b0;
            r_err        <= 1'b0;
            r_conv_idx   <= '0;
            r_acc        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_pend_digit <= in_digit;
                r_pend_last  <= w_in_last;
                r_err        <= w_in_err;
            end
            if (w_place_done) begin
                r_idx <= r_idx + IW'(1);
            end
            if (r_state == CONV) begin
                r_conv_idx <= r_conv_idx + DW'(1);
                if (r_conv_idx < w_depth) begin
                    r_acc <= r_acc * VALUE_WIDTH'(TEN) + VALUE_WIDTH'(w_rd_data);
                end
            end
            if (r_state == EMIT) begin
                r_idx      <= '0;
                r_acc      <= '0;
                r_conv_idx <= '0;
                r_err      <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == FILL);
    assign busy      = (r_state != FILL);
    assign out_valid = (r_state == EMIT);
    assign out_value = (r_state == EMIT) ? r_acc : '0;
    assign out_err   = (r_state == EMIT) && r_err;

`ifdef MAX_SUBSEQ_PICKER_ACC_EN
    logic [SUM_WIDTH-1:0] r_total;

    // clear takes effect before the add when both land on the EMIT cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_total <= '0;
        end else if (r_state == EMIT) begin
            r_total <= (clear ? '0 : r_total) + SUM_WIDTH'(r_acc);
        end else if (clear) begin
            r_total <= '0;
        end
    end

    assign total = r_total;
`else
    logic w_unused_clear;
    assign w_unused_clear = clear;
    assign total          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_max_subseq_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_max_subseq_picker : self-checking bench, DIGITS=2 and DIGITS=12    |
// | instances on 15-digit lines. Honours MAX_SUBSEQ_PICKER_ACC_EN.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif

module tb_max_subseq_picker;

`ifdef MAX_SUBSEQ_PICKER_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif
    localparam int LINE_LEN = 15;
    localparam int DWID     = `DATA_WIDTH;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic            a_in_valid = 1'b0, a_in_last = 1'b0, a_clear = 1'b0;
    logic [DWID-1:0] a_in_digit = '0;
    logic            a_in_ready, a_out_valid, a_out_err, a_busy;
    logic [39:0]     a_out_value;
    logic [63:0]     a_total;

    logic            b_in_valid = 1'b0, b_in_last = 1'b0, b_clear = 1'b0;
    logic [DWID-1:0] b_in_digit = '0;
    logic            b_in_ready, b_out_valid, b_out_err, b_busy;
    logic [39:0]     b_out_value;
    logic [63:0]     b_total;

    max_subseq_picker #(.DIGITS(2), .LINE_LEN(LINE_LEN), .VALUE_WIDTH(40), .SUM_WIDTH(64)) u_a (
        .clock(clock), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_digit(a_in_digit), .in_last(a_in_last), .clear(a_clear), .out_valid(a_out_valid),
        .out_value(a_out_value), .out_err(a_out_err), .total(a_total), .busy(a_busy)
    );

    max_subseq_picker #(.DIGITS(12), .LINE_LEN(LINE_LEN), .VALUE_WIDTH(40), .SUM_WIDTH(64)) u_b (
        .clock(clock), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_digit(b_in_digit), .in_last(b_in_last), .clear(b_clear), .out_valid(b_out_valid),
        .out_value(b_out_value), .out_err(b_out_err), .total(b_total), .busy(b_busy)
    );

    int errors = 0;
    int checks = 0;

    logic [39:0] qa_val[$], qb_val[$];
    bit          qa_err[$], qb_err[$];

    always @(negedge clock) begin
        if (a_out_valid) begin qa_val.push_back(a_out_value); qa_err.push_back(a_out_err); end
        if (b_out_valid) begin qb_val.push_back(b_out_value); qb_err.push_back(b_out_err); end
    end

    // Largest k-subsequence by greedy window maximum over the whole line
    function automatic longint unsigned best_subseq(input string s, input int k);
        longint unsigned v = 0;
        int start = 0;
        int n = s.len();
        for (int j = 0; j < k; j++) begin
            int bp = start;
            for (int p = start; p <= n - k + j; p++) begin
                if (s[p] > s[bp]) bp = p;
            end
            v = v * 10 + longint'(int'(s[bp]) - 48);
            start = bp + 1;
        end
        return v;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic send_digit(input int which, input int d, input bit last, output int stalls);
        bit rdy, done;
        stalls = 0;
        done   = 1'b0;
        @(negedge clock);
        if (which == 0) begin a_in_valid = 1'b1; a_in_digit = DWID'(d); a_in_last = last; end
        else            begin b_in_valid = 1'b1; b_in_digit = DWID'(d); b_in_last = last; end
        for (int n = 0; n < 64 && !done; n++) begin
            rdy = (which == 0) ? a_in_ready : b_in_ready;
            @(posedge clock);
            if (rdy) done = 1'b1;
            else begin
                stalls++;
                @(negedge clock);
            end
        end
        #1;
        a_in_valid = 1'b0; a_in_last = 1'b0;
        b_in_valid = 1'b0; b_in_last = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL handshake_timeout dut=%0d: in_ready never high, required a handshake within 64 cycles", which);
        end
    endtask

    task automatic send_line(input int which, input string s, input int last_at, input bit gap,
                             output int stalls);
        int st;
        stalls = 0;
        for (int i = 0; i < s.len(); i++) begin
            send_digit(which, int'(s[i]) - 48, (i == last_at), st);
            stalls += st;
            if (gap) repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    task automatic wait_outs(input int which, input int count);
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            #1;
            if (((which == 0) ? qa_val.size() : qb_val.size()) >= count) break;
        end
        @(negedge clock);
        #1;
    endtask

    task automatic clear_queues();
        qa_val.delete(); qa_err.delete(); qb_val.delete(); qb_err.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_in_ready, a_out_valid, a_out_err, a_busy} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags_a: got %b, expected 1000", {a_in_ready, a_out_valid, a_out_err, a_busy});
        end
        checks++;
        if ({b_in_ready, b_out_valid, b_out_err, b_busy} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags_b: got %b, expected 1000", {b_in_ready, b_out_valid, b_out_err, b_busy});
        end
        checks++;
        if (a_out_value !== 40'd0 || b_out_value !== 40'd0) begin
            errors++; $display("FAIL reset_value: got %0d/%0d, expected 0/0", a_out_value, b_out_value);
        end
        checks++;
        if (a_total !== 64'd0 || b_total !== 64'd0) begin
            errors++; $display("FAIL reset_total: got %0d/%0d, expected 0/0", a_total, b_total);
        end
    endtask

    task automatic test_aoc_lines();
        string       lines [4] = '{"987654321111111", "811111111111119", "234234234234278", "818181911112111"};
        logic [39:0] exp_a [4] = '{40'd98, 40'd89, 40'd78, 40'd92};
        logic [39:0] exp_b [4] = '{40'd987654321111, 40'd811111111119, 40'd434234234278, 40'd888911112111};
        int st;
        do_reset();
        clear_queues();
        for (int i = 0; i < 4; i++) begin
            send_line(0, lines[i], LINE_LEN - 1, 1'b0, st);
            if (i == 0) begin
                checks++;
                if (st !== 0) begin errors++; $display("FAIL back_to_back_a: got %0d stall cycles, expected 0", st); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            send_line(1, lines[i], LINE_LEN - 1, 1'b0, st);
            if (i == 0) begin
                checks++;
                if (st !== 0) begin errors++; $display("FAIL back_to_back_b: got %0d stall cycles, expected 0", st); end
            end
        end
        wait_outs(0, 4);
        wait_outs(1, 4);
        checks++;
        if (qa_val.size() != 4 || qb_val.size() != 4) begin
            errors++; $display("FAIL aoc_count: got %0d/%0d results, expected 4/4", qa_val.size(), qb_val.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (qa_val[i] !== exp_a[i] || qa_err[i] !== 1'b0) begin
                    errors++; $display("FAIL aoc_a[%0d]: got %0d err %0b, expected %0d err 0", i, qa_val[i], qa_err[i], exp_a[i]);
                end
                checks++;
                if (qb_val[i] !== exp_b[i] || qb_err[i] !== 1'b0) begin
                    errors++; $display("FAIL aoc_b[%0d]: got %0d err %0b, expected %0d err 0", i, qb_val[i], qb_err[i], exp_b[i]);
                end
            end
        end
        checks++;
        if (a_total !== (ACC ? 64'd357 : 64'd0)) begin
            errors++; $display("FAIL total_a: got %0d, expected %0d", a_total, ACC ? 357 : 0);
        end
        checks++;
        if (b_total !== (ACC ? 64'd3121910778619 : 64'd0)) begin
            errors++; $display("FAIL total_b: got %0d, expected %0d", b_total, ACC ? 64'd3121910778619 : 64'd0);
        end
    endtask

    task automatic test_pop_stall();
        int st, lat;
        logic [39:0] val;
        logic        err;
        bit          seen;
        do_reset();
        clear_queues();
        send_line(1, "123456789012345", LINE_LEN - 1, 1'b0, st);
        checks++;
        if (st !== 3) begin errors++; $display("FAIL pop_stalls: got %0d, expected 3", st); end
        lat = 0; seen = 1'b0; val = '0; err = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clock);
            lat++;
            if (b_out_valid) begin seen = 1'b1; val = b_out_value; err = b_out_err; end
        end
        checks++;
        if (!seen || lat !== 13) begin errors++; $display("FAIL emit_latency: got %0d (seen=%0b), expected 13", lat, seen); end
        checks++;
        if (val !== 40'd456789012345 || err !== 1'b0) begin
            errors++; $display("FAIL rising_value: got %0d err %0b, expected 456789012345 err 0", val, err);
        end
    endtask

    task automatic test_bad_length();
        int st;
        do_reset();
        clear_queues();
        send_line(0, "12345", 4, 1'b0, st);
        wait_outs(0, 1);
        checks++;
        if (qa_val.size() != 1 || qa_val[0] !== 40'd45 || qa_err[0] !== 1'b1) begin
            errors++; $display("FAIL short_line: got n=%0d val=%0d err=%0b, expected n=1 val=45 err=1",
                               qa_val.size(), (qa_val.size() > 0) ? qa_val[0] : 40'd0, (qa_err.size() > 0) ? qa_err[0] : 1'b0);
        end
        send_line(0, "811111111111119", -1, 1'b0, st);
        wait_outs(0, 2);
        checks++;
        if (qa_val.size() != 2 || qa_val[1] !== 40'd89 || qa_err[1] !== 1'b1) begin
            errors++; $display("FAIL forced_end: got n=%0d val=%0d err=%0b, expected n=2 val=89 err=1",
                               qa_val.size(), (qa_val.size() > 1) ? qa_val[1] : 40'd0, (qa_err.size() > 1) ? qa_err[1] : 1'b0);
        end
        checks++;
        if (a_total !== (ACC ? 64'd134 : 64'd0)) begin
            errors++; $display("FAIL bad_length_total: got %0d, expected %0d", a_total, ACC ? 134 : 0);
        end
    endtask

    task automatic test_reset_midline();
        int st;
        do_reset();
        clear_queues();
        send_line(0, "8181819", -1, 1'b0, st);
        do_reset();
        send_line(0, "987654321111111", LINE_LEN - 1, 1'b0, st);
        wait_outs(0, 1);
        repeat (20) @(negedge clock);
        checks++;
        if (qa_val.size() != 1 || qa_val[0] !== 40'd98) begin
            errors++; $display("FAIL reset_midline: got n=%0d val=%0d, expected n=1 val=98",
                               qa_val.size(), (qa_val.size() > 0) ? qa_val[0] : 40'd0);
        end
        checks++;
        if (a_total !== (ACC ? 64'd98 : 64'd0)) begin
            errors++; $display("FAIL reset_midline_total: got %0d, expected %0d", a_total, ACC ? 98 : 0);
        end
        send_line(1, "987654321111111", LINE_LEN - 1, 1'b0, st);
        repeat (4) @(negedge clock);
        do_reset();
        repeat (30) @(negedge clock);
        checks++;
        if (qb_val.size() != 0 || b_total !== 64'd0) begin
            errors++; $display("FAIL reset_midconv: got n=%0d total=%0d, expected n=0 total=0", qb_val.size(), b_total);
        end
    endtask

    task automatic test_clear();
        int st;
        bit seen;
        do_reset();
        clear_queues();
        send_line(0, "987654321111111", LINE_LEN - 1, 1'b0, st);
        wait_outs(0, 1);
        send_line(0, "811111111111119", LINE_LEN - 1, 1'b0, st);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clock);
            if (a_out_valid) seen = 1'b1;
        end
        a_clear = 1'b1;
        @(posedge clock);
        #1;
        a_clear = 1'b0;
        @(negedge clock);
        checks++;
        if (!seen || a_total !== (ACC ? 64'd89 : 64'd0)) begin
            errors++; $display("FAIL clear_on_emit: got %0d (seen=%0b), expected %0d", a_total, seen, ACC ? 89 : 0);
        end
    endtask

    task automatic test_random();
        string           s;
        int              st;
        logic [39:0]     exp_a[$], exp_b[$];
        longint unsigned sum_a = 0, sum_b = 0;
        do_reset();
        clear_queues();
        for (int l = 0; l < 20; l++) begin
            s = "";
            for (int i = 0; i < LINE_LEN; i++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
            exp_a.push_back(40'(best_subseq(s, 2)));
            exp_b.push_back(40'(best_subseq(s, 12)));
            sum_a += best_subseq(s, 2);
            sum_b += best_subseq(s, 12);
            send_line(0, s, LINE_LEN - 1, 1'b1, st);
            send_line(1, s, LINE_LEN - 1, 1'b1, st);
        end
        wait_outs(0, 20);
        wait_outs(1, 20);
        checks++;
        if (qa_val.size() != 20 || qb_val.size() != 20) begin
            errors++; $display("FAIL random_count: got %0d/%0d, expected 20/20", qa_val.size(), qb_val.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (qa_val[i] !== exp_a[i] || qa_err[i] !== 1'b0) begin
                    errors++; $display("FAIL random_a[%0d]: got %0d err %0b, expected %0d err 0", i, qa_val[i], qa_err[i], exp_a[i]);
                end
                checks++;
                if (qb_val[i] !== exp_b[i] || qb_err[i] !== 1'b0) begin
                    errors++; $display("FAIL random_b[%0d]: got %0d err %0b, expected %0d err 0", i, qb_val[i], qb_err[i], exp_b[i]);
                end
            end
        end
        checks++;
        if (a_total !== (ACC ? 64'(sum_a) : 64'd0) || b_total !== (ACC ? 64'(sum_b) : 64'd0)) begin
            errors++; $display("FAIL random_total: got %0d/%0d, expected %0d/%0d", a_total, b_total,
                               ACC ? sum_a : 64'd0, ACC ? sum_b : 64'd0);
        end
    endtask

    initial begin
        test_reset();
        test_aoc_lines();
        test_pop_stall();
        test_bad_length();
        test_reset_midline();
        test_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/max_subseq_picker.md
# max_subseq_picker

Streaming per-line selector that keeps the lexicographically largest DIGITS-long subsequence of each LINE_LEN-digit input line, using a monotonic digit stack. At end of line it serially converts the kept decimal digits to binary, emits the value, and optionally accumulates a running total. It is the parametrised successor to the fixed 12-digit line picker. A single instance covers both the 2-digit and 12-digit puzzle modes by setting DIGITS.

## Interface
- DIGITS, 12: digits kept per line (K); 1..LINE_LEN.
- LINE_LEN, 100: digits per well-formed line; ≥ DIGITS.
- VALUE_WIDTH, 40: per-line result width; must be ≥ ceil(DIGITS·log2 10).
- SUM_WIDTH, 64: accumulator width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_digit/in_last valid.
- in_ready  out  1  block accepts a digit this cycle.
- in_digit  in  `DATA_WIDTH  decimal digit 0–9; other values are illegal stimulus.
- in_last  in  1  marks final digit of the line.
- clear  in  1  synchronous clear of total (macro build only; ignored otherwise).
- out_valid  out  1  one-cycle pulse, result ready.
- out_value  out  VALUE_WIDTH  selected number for the line.
- out_err  out  1  qualified by out_valid; line length ≠ LINE_LEN.
- total  out  SUM_WIDTH  running sum (macro build only).
- busy  out  1  state ≠ FILL.

## Operation
- Stack: DIGITS entries, depth 0..DIGITS; idx counts accepted digits in line (0-based).
- Remaining r = LINE_LEN − idx for the digit being placed, saturated to ≥1.
- Pop condition: depth>0 ∧ top<d ∧ (depth−1+r) ≥ DIGITS.
- Place action, one per cycle: if pop condition then pop; else push d if depth<DIGITS, else discard d.
- States:
  - FILL: in_ready=1. On handshake, perform the first action on the new digit. If it was a pop, latch d/last into pending and go to POP. Otherwise the digit is done: stay in FILL, or go to CONV if last.
  - POP: in_ready=0. One action per cycle on pending. When the push/discard happens, go to FILL, or go to CONV if pending was last.
  - CONV: one cycle per stacked entry, bottom first: acc = acc·10 + entry. Runs depth cycles, so fewer than DIGITS when the line was short.
  - EMIT: out_valid=1, out_value=acc. Add to total. Clear depth, idx and acc. Go to FILL.
- out_err=1 when in_last arrives with idx≠LINE_LEN−1.
- out_err=1 also when digit idx LINE_LEN−1 arrives without in_last. In that case the line is force-terminated as if last were set.
- Arithmetic: out_value is unsigned. total wraps modulo 2^SUM_WIDTH. No saturation.

## Timing
- Reset (async assert, sync deassert): state FILL, in_ready=1, out_valid=0, out_value=0, out_err=0, total=0, busy=0, stack empty.
- Per digit: 1+P cycles, where P is the number of pops it causes. Back-to-back pushes sustain 1 digit/cycle.
- Latency from the last digit's final action to out_valid: depth + 1 cycles.
- in_ready is low in POP, CONV and EMIT. Upstream holds in_valid/data until the handshake.
- clear concurrent with EMIT: total loads out_value (clear applied first, then add).
- reset_n asserted mid-line or mid-CONV: the partial line is discarded and no out_valid is produced.

## Configuration
- MAX_SUBSEQ_PICKER_ACC_EN defined: total register, clear input and accumulate-on-EMIT are present.
- Not defined: total is driven to 0 and clear is unused. Per-line behaviour is identical.

## Structure
- aoc_pkg holds:
  - the state enum typedef (FILL, POP, CONV, EMIT);
  - digit_t, sized from `DATA_WIDTH;
  - the constant TEN.
- Sub-module digit_stack: LIFO with push, pop, peek-top, depth and indexed read for CONV.
- The top block holds the FSM, idx, conversion and accumulator.

## Test plan
- DIGITS=2, LINE_LEN=15, input lines 987654321111111, 811111111111119, 234234234234278, 818181911112111 -> out_value 98, 89, 78, 92; total 357; out_err=0.
- DIGITS=12, same four lines -> out_value 987654321111, 811111111119, 434234234278, 888911112111; total 3121910778619.
- DIGITS=12, line 123456789012345 (strictly rising prefix) -> pops show in_ready low for P cycles; out_value 456789012345.
- DIGITS=2, LINE_LEN=15, in_last on the 5th digit of 12345 -> out_valid with out_value 45, out_err=1.
- reset_n pulsed low mid-line, then a full line 987654321111111 with DIGITS=2 -> only one out_valid, value 98; total 98.
- clear asserted in the EMIT cycle of line 2 (DIGITS=2) -> total equals line-2 value 89.
- Macro undefined -> total constantly 0.
